// File: rtl/despachador_destinos_pkg.sv
// Shared types for the destination dispatcher, destination queue and elevator
// controller: floor codes, dispatcher FSM states and gap timer width.
package despachador_destinos_pkg;

    typedef enum logic [1:0] {
        MINUS_ONE = 2'b00,
        ONE       = 2'b01,
        TWO       = 2'b10,
        THREE     = 2'b11
    } floor_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        ISSUE    = 3'd2,
        WAIT_ARR = 3'd3,
        GAP      = 3'd4,
        DONE     = 3'd5
    } state_e;

    localparam int GAP_W = 16;

endpackage

// File: rtl/despachador_destinos_contador.sv
// contador_espera: 16-bit down-counter timing the idle gap between arrivals.
// Ports: clk, reset, load_i/val_i (preload), en_i (decrement), zero_o (count==0).
module contador_espera
    import despachador_destinos_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [GAP_W-1:0] val_i,
    output logic             zero_o
);

    logic [GAP_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/despachador_destinos.sv
// Walks the destination queue, issuing one floor request per entry, waiting
// for arrival, then idling GAP_CYCLES before the next fetch.
// Ports: clk, reset, start, address/destino (queue), req_valid/req_ready/
// req_floor (controller), arrived, busy, done, served.
module despachador_destinos
    import despachador_destinos_pkg::*;
#(
    parameter int QUEUE_LEN  = 10,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  address,
    input  logic [23:0] destino,
    output logic        req_valid,
    output logic [1:0]  req_floor,
    input  logic        req_ready,
    input  logic        arrived,
    output logic        busy,
    output logic        done,
    output logic [7:0]  served
);

    localparam logic [7:0]       LAST     = 8'(QUEUE_LEN - 1);
    // The gap counter is loaded on the arrival edge and the FSM leaves GAP
    // on the cycle it reads zero, so N-1 gives exactly N GAP cycles.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] served_q, served_d;
    floor_e     floor_q, floor_d;
    logic       gap_load, gap_en, gap_zero;

    // Only the floor code of a queue word matters.
    logic unused_destino;
    assign unused_destino = ^destino[23:2];

    contador_espera u_gap (
        .clk    (clk),
        .reset  (reset),
        .load_i (gap_load),
        .en_i   (gap_en),
        .val_i  (GAP_LOAD),
        .zero_o (gap_zero)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        served_d = served_q;
        floor_d  = floor_q;
        gap_load = 1'b0;
        gap_en   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = FETCH;
                    addr_d   = '0;
                    served_d = '0;
                end
            end
            FETCH: begin
                floor_d = floor_e'(destino[1:0]);
                state_d = ISSUE;
            end
            ISSUE: begin
                if (req_ready) begin
                    state_d = WAIT_ARR;
                end
            end
            WAIT_ARR: begin
                if (arrived) begin
                    served_d = served_q + 8'd1;
                    gap_load = 1'b1;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (gap_zero) begin
                    if (addr_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        state_d = FETCH;
                    end
                end else begin
                    gap_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            served_q <= '0;
            floor_q  <= MINUS_ONE;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            served_q <= served_d;
            floor_q  <= floor_d;
        end
    end

    assign address   = addr_q;
    assign served    = served_q;
    assign req_floor = floor_q;
    assign req_valid = (state_q == ISSUE);
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);

endmodule

// File: doc/despachador_destinos.md
DESPACHADOR_DESTINOS -- requirements
Module: despachador_destinos

Interface
REQ-001 Parameter QUEUE_LEN, default 10: number of valid entries in the external-destination queue, indexed 0..QUEUE_LEN-1.
REQ-002 Parameter GAP_CYCLES, default 4: idle cycles inserted after each arrival before the next fetch; legal range 1..65535.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: level; begins a dispatch run when sampled high in IDLE or DONE.
REQ-006 Port address, output, 8: index presented to the destination queue.
REQ-007 Port destino, input, 24: destination word returned combinationally by the queue for the current address.
REQ-008 Port req_valid, output, 1: floor request pending toward the elevator controller.
REQ-009 Port req_floor, output, 2: requested floor code (00 = -1, 01 = 1, 10 = 2, 11 = 3).
REQ-010 Port req_ready, input, 1: controller accepts the request when high together with req_valid.
REQ-011 Port arrived, input, 1: single-cycle pulse; controller reached the accepted floor.
REQ-012 Port busy, output, 1: high in every state except IDLE and DONE.
REQ-013 Port done, output, 1: high in DONE only.
REQ-014 Port served, output, 8: count of arrivals completed in the current run.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, ISSUE, WAIT_ARR, GAP and DONE.
REQ-016 IDLE/DONE with start=1 -> FETCH; address <= 0; served <= 0.
REQ-017 FETCH SHALL last exactly one cycle, register destino[1:0] into req_floor, and go to ISSUE.
REQ-018 destino[23:2] SHALL be ignored.
REQ-019 ISSUE SHALL hold req_valid=1 and keep req_floor stable until the handshake completes; a handshake is req_valid&req_ready on a rising edge, and ISSUE then goes to WAIT_ARR with req_valid deasserted the next cycle.
REQ-020 A req_ready that is already high on the first ISSUE cycle SHALL complete the handshake in that cycle, giving 1 cycle of req_valid.
REQ-021 arrived SHALL be ignored outside WAIT_ARR.
REQ-022 In WAIT_ARR, arrived=1 SHALL increment served and go to GAP.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles using a 16-bit down-counter.
REQ-024 At the end of GAP: if address == QUEUE_LEN-1, go to DONE; otherwise address <= address+1 and go to FETCH.
REQ-025 address SHALL never exceed QUEUE_LEN-1 and SHALL hold its value in WAIT_ARR, GAP and DONE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 done SHALL remain high until a new start or reset.
REQ-028 A start held high in DONE SHALL restart the run on the next cycle.
REQ-029 Request-to-floor latency: req_valid SHALL first assert 2 cycles after the start sample (FETCH, then ISSUE).

Reset
REQ-030 reset=1 SHALL, from any state, force on the next edge: state = IDLE, address = 0, req_valid = 0, req_floor = 00, served = 0, busy = 0, done = 0, and the gap counter = 0.
REQ-031 Reset SHALL take priority over start, req_ready and arrived in the same cycle.
REQ-032 A request pending at reset SHALL be dropped without completing a handshake.

Structure
REQ-033 The floor codes (MINUS_ONE=00, ONE=01, TWO=10, THREE=11) and the FSM state encoding SHALL live in a shared package, also used by the destination queue and the elevator controller.
REQ-034 The GAP timer SHALL be one sub-module named contador_espera, with load, count-enable and a zero flag.
REQ-035 No other sub-modules SHALL be used.

Verification
REQ-036 The bench SHALL run a full run with QUEUE_LEN=10, GAP_CYCLES=4, the standard queue contents, req_ready tied to 1, and arrived pulsed 3 cycles after each handshake, and SHALL check:
- req_floor sequence 11,00,10,01,11,01,00,10,11,01;
- served=10;
- done=1;
- address=9.
REQ-037 The bench SHALL hold req_ready=0 for 5 cycles in ISSUE and check that req_valid stays high with req_floor unchanged, then raise req_ready and check exactly one handshake.
REQ-038 The bench SHALL pulse arrived during ISSUE and GAP, check that served is unchanged and the state is unaffected, and check that the next arrived in WAIT_ARR increments served by 1.
REQ-039 The bench SHALL assert reset during WAIT_ARR at address 4 and check next cycle: IDLE, address=0, served=0, req_valid=0, busy=0.
REQ-040 The bench SHALL pulse start mid-run at address 2 and check no effect; then after DONE it SHALL pulse start and check address=0, served=0, done=0, and req_valid asserting 2 cycles later.
REQ-041 The bench SHALL drive destino=24'hFFFFFE at one entry and check req_floor=10.
